rgb2luma_pipe: RTL and testbench
================================

// Module: rgb2luma_pipe
// PURPOSE
//  Parametrised RGB->luma converter for the video pipeline front end, ahead of the brightness
//  statistics and curve blocks. Four selectable modes: average, BT.601, BT.709, max-channel.
//  Fixed 3-cycle latency in every mode, with a pipeline clock-enable for back-pressure.
//  Mode changes take effect only at frame boundaries. Sync/de and the source RGB stay aligned.
// PARAMETERS
//  DW      8  bits per colour channel and per luma output
//  VS_POL  1  vsync active level (1 = active-high); frame start = vsync edge into active level
//  CW      8  fractional bits of the BT coefficients (weights sum to 2^CW)
// PORTS
//  clk       in   1     clock
//  rst_n     in   1     asynchronous active-low reset
//  ce        in   1     pipeline enable; 0 = every register holds
//  cfg_mode  in   2     requested mode: 0 avg, 1 BT.601, 2 BT.709, 3 max
//  r,g,b     in   DW    input pixel
//  vsync     in   1     input vertical sync
//  hsync     in   1     input horizontal sync
//  de        in   1     input data enable
//  y_vsync   out  1     vsync delayed 3 enabled cycles
//  y_hsync   out  1     hsync delayed 3 enabled cycles
//  y_de      out  1     de delayed 3 enabled cycles
//  y         out  DW    luma
//  rgb_out   out  3*DW  {r,g,b}, delayed 3 enabled cycles
//  mode_act  out  2     mode applied to the pixel currently on y
// BEHAVIOUR
//  - Reset: all pipeline regs, all outputs, mode shadow and vsync-edge reg = 0. Reset mode = avg.
//  - Reset mid-frame: pipeline is flushed. y_de = 0 until 3 enabled cycles after release.
//  - ce=1: pipeline advances one stage per clk. ce=0: every register holds, including the
//    mode shadow and the edge detector. Latency is measured in ce=1 cycles.
//  - Mode shadow: vs_d <= vsync on each enabled cycle. On an enabled cycle where vsync==VS_POL
//    and vs_d!=VS_POL, the shadow loads cfg_mode. That pixel and all later ones use the new mode.
//    cfg_mode changes at any other time are ignored until the next frame start.
//  - Each pixel's mode tag travels with it through all 3 stages. Pixels already in flight
//    complete in their original mode. mode_act is the stage-3 tag.
//  - S1 (per mode):
//      avg     p0=r+g (DW+1 bits), p1=b
//      BT      p0=Kr*r, p1=Kg*g, p2=Kb*b (DW+CW bits each)
//      max     p0=max(r,g), p1=b
//  - S2: sum. avg: s=p0+p1 (DW+2 bits). BT: s=p0+p1+p2+2^(CW-1). max: s=max(p0,p1).
//  - S3 -> y:
//      avg     floor(s/3), exact for all inputs; implemented as (s*RECIP3)>>SH3
//      BT      s>>CW, clamped to 2^DW-1
//      max     s
//  - Coefficients at CW=8: BT.601 Kr/Kg/Kb = 77/150/29; BT.709 = 54/183/19.
//  - Sync/de/rgb: plain 3-stage shift registers with the same ce. No gating by de.
//    y is computed every enabled cycle regardless of de.
//  - Simultaneous frame start and cfg_mode change in the same cycle: the new cfg_mode value
//    is loaded.
// STRUCTURE
//  - rgb2luma_pkg:
//      mode localparams MODE_AVG/601/709/MAX
//      coefficient tables per CW
//      RECIP3/SH3 as functions of DW
//      clamp function
//  - One sub-module, luma_core: the 3-stage arithmetic datapath with mode tag and ce.
//    Top level holds the mode shadow, vsync edge detect and sync/rgb delay lines.
// TESTING
//  1. mode 0, (255,255,255) with de=1 -> y=255 exactly 3 clks later, y_de aligned;
//     (1,1,0) -> 0; (2,2,2) -> 2.
//  2. Frame start with cfg_mode=1, pixel (255,0,0) -> y=77, mode_act=1.
//     cfg_mode=2, pixel (0,255,0) -> y=182.
//  3. cfg_mode=3, pixel (10,200,30) -> y=200; rgb_out=0x0AC81E 3 clks later.
//  4. Change cfg_mode 0->1 mid-frame: y stays avg until the next vsync rising edge.
//     At the boundary, in-flight pixels keep mode 0 and the first new-frame pixel uses mode 1.
//  5. ce low for 5 cycles mid-line: all outputs frozen. On resume, the output sequence is
//     identical to a run with no stall.
//  6. Assert rst_n mid-frame: outputs 0 immediately. After release, mode_act=0 and y_de=0
//     for 3 clks. Exhaustive avg check over all 8-bit triples vs floor(sum/3).

Source files
------------

// File: rtl/rgb2luma_pkg.sv
// Shared constants and helpers for the RGB->luma converter: mode encodings,
// BT coefficient tables, divide-by-3 reciprocal and saturation.
package rgb2luma_pkg;

    localparam logic [1:0] MODE_AVG = 2'd0;
    localparam logic [1:0] MODE_601 = 2'd1;
    localparam logic [1:0] MODE_709 = 2'd2;
    localparam logic [1:0] MODE_MAX = 2'd3;

    // Rescales an 8-fractional-bit coefficient to cw fractional bits (rounded).
    function automatic int coef_scale(input int k8, input int cw);
        if (cw >= 8)
            return k8 << (cw - 8);
        else
            return (k8 + (1 << (7 - cw))) >> (8 - cw);
    endfunction

    function automatic int kr_coef(input logic [1:0] mode, input int cw);
        return coef_scale((mode == MODE_709) ? 54 : 77, cw);
    endfunction

    function automatic int kb_coef(input logic [1:0] mode, input int cw);
        return coef_scale((mode == MODE_709) ? 19 : 29, cw);
    endfunction

    // Green absorbs the rounding so the three weights always sum to 2^cw.
    function automatic int kg_coef(input logic [1:0] mode, input int cw);
        return (1 << cw) - kr_coef(mode, cw) - kb_coef(mode, cw);
    endfunction

    // Odd shift makes ceil(2^k/3)*3 - 2^k == 1, so the reciprocal is exact
    // for every sum below 2^(dw+2).
    function automatic int sh3(input int dw);
        int k;
        k = dw + 2;
        if ((k % 2) == 0)
            k = k + 1;
        return k;
    endfunction

    function automatic int recip3(input int dw);
        return ((1 << sh3(dw)) + 1) / 3;
    endfunction

    function automatic logic [31:0] clamp_u(input logic [31:0] v, input int dw);
        logic [31:0] lim;
        lim = 32'((1 << dw) - 1);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/rgb2luma_pipe_core.sv
// luma_core: three-stage luma datapath (products, sum, normalise) with a
// per-pixel mode tag travelling alongside the data.
module luma_core
    import rgb2luma_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] g,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y,
    output logic [1:0]    mode_out
);

    localparam int PW = (CW >= 1) ? DW + CW : DW + 1;
    localparam int SW = PW + 2;
    localparam int SH = sh3(DW);
    localparam int MW = SW + SH;

    localparam logic [PW-1:0] KR601 = PW'(kr_coef(MODE_601, CW));
    localparam logic [PW-1:0] KG601 = PW'(kg_coef(MODE_601, CW));
    localparam logic [PW-1:0] KB601 = PW'(kb_coef(MODE_601, CW));
    localparam logic [PW-1:0] KR709 = PW'(kr_coef(MODE_709, CW));
    localparam logic [PW-1:0] KG709 = PW'(kg_coef(MODE_709, CW));
    localparam logic [PW-1:0] KB709 = PW'(kb_coef(MODE_709, CW));
    localparam logic [SW-1:0] RND   = SW'(1) << (CW - 1);
    localparam logic [MW-1:0] RECIP = MW'(recip3(DW));

    logic [PW-1:0] p0_n, p1_n, p2_n;
    logic [PW-1:0] p0_q, p1_q, p2_q;
    logic [1:0]    m1_q, m2_q, m3_q;
    logic [SW-1:0] s_n, s_q;
    logic [SW-1:0] bt_sh;
    logic [MW-1:0] prod;
    logic [DW-1:0] y_n, y_q;

    always_comb begin
        p0_n = '0;
        p1_n = '0;
        p2_n = '0;
        case (mode)
            MODE_AVG: begin
                p0_n = PW'(r) + PW'(g);
                p1_n = PW'(b);
            end
            MODE_601: begin
                p0_n = PW'(r) * KR601;
                p1_n = PW'(g) * KG601;
                p2_n = PW'(b) * KB601;
            end
            MODE_709: begin
                p0_n = PW'(r) * KR709;
                p1_n = PW'(g) * KG709;
                p2_n = PW'(b) * KB709;
            end
            default: begin
                p0_n = (r > g) ? PW'(r) : PW'(g);
                p1_n = PW'(b);
            end
        endcase
    end

    always_comb begin
        case (m1_q)
            MODE_AVG: s_n = SW'(p0_q) + SW'(p1_q);
            MODE_MAX: s_n = (p0_q > p1_q) ? SW'(p0_q) : SW'(p1_q);
            default:  s_n = SW'(p0_q) + SW'(p1_q) + SW'(p2_q) + RND;
        endcase
    end

    always_comb begin
        prod  = MW'(s_q) * RECIP;
        bt_sh = s_q >> CW;
        case (m2_q)
            MODE_AVG: y_n = DW'(prod >> SH);
            MODE_MAX: y_n = s_q[DW-1:0];
            default:  y_n = DW'(clamp_u(32'(bt_sh), DW));
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_q <= '0;
            p1_q <= '0;
            p2_q <= '0;
            m1_q <= MODE_AVG;
            s_q  <= '0;
            m2_q <= MODE_AVG;
            y_q  <= '0;
            m3_q <= MODE_AVG;
        end else if (ce) begin
            p0_q <= p0_n;
            p1_q <= p1_n;
            p2_q <= p2_n;
            m1_q <= mode;
            s_q  <= s_n;
            m2_q <= m1_q;
            y_q  <= y_n;
            m3_q <= m2_q;
        end
    end

    assign y        = y_q;
    assign mode_out = m3_q;

endmodule

// File: rtl/rgb2luma_pipe.sv
// RGB->luma front end: frame-synchronous mode shadow, luma datapath and
// matching 3-stage delay lines for sync, de and source RGB.
module rgb2luma_pipe
    import rgb2luma_pkg::*;
#(
    parameter int   DW     = 8,
    parameter logic VS_POL = 1'b1,
    parameter int   CW     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic [1:0]      cfg_mode,
    input  logic [DW-1:0]   r,
    input  logic [DW-1:0]   g,
    input  logic [DW-1:0]   b,
    input  logic            vsync,
    input  logic            hsync,
    input  logic            de,
    output logic            y_vsync,
    output logic            y_hsync,
    output logic            y_de,
    output logic [DW-1:0]   y,
    output logic [3*DW-1:0] rgb_out,
    output logic [1:0]      mode_act
);

    // Flow control: ce is a global stall, not a handshake. With ce low every
    // register (datapath, delay lines, shadow, edge detector) holds its value.
    logic            vs_d;
    logic [1:0]      mode_sh;
    logic [1:0]      cur_mode;
    logic            frame_start;
    logic [2:0]      vs_pipe, hs_pipe, de_pipe;
    logic [3*DW-1:0] rgb_pipe [3];

    assign frame_start = (vsync == VS_POL) && (vs_d != VS_POL);
    // The frame-start pixel itself already uses the newly requested mode.
    assign cur_mode    = frame_start ? cfg_mode : mode_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d    <= 1'b0;
            mode_sh <= MODE_AVG;
        end else if (ce) begin
            vs_d <= vsync;
            if (frame_start)
                mode_sh <= cfg_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_pipe  <= '0;
            hs_pipe  <= '0;
            de_pipe  <= '0;
            rgb_pipe <= '{default: '0};
        end else if (ce) begin
            vs_pipe     <= {vs_pipe[1:0], vsync};
            hs_pipe     <= {hs_pipe[1:0], hsync};
            de_pipe     <= {de_pipe[1:0], de};
            rgb_pipe[0] <= {r, g, b};
            rgb_pipe[1] <= rgb_pipe[0];
            rgb_pipe[2] <= rgb_pipe[1];
        end
    end

    luma_core #(
        .DW (DW),
        .CW (CW)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .mode     (cur_mode),
        .r        (r),
        .g        (g),
        .b        (b),
        .y        (y),
        .mode_out (mode_act)
    );

    assign y_vsync = vs_pipe[2];
    assign y_hsync = hs_pipe[2];
    assign y_de    = de_pipe[2];
    assign rgb_out = rgb_pipe[2];

endmodule

// File: tb/tb_rgb2luma_pipe.sv
// Directed bench for rgb2luma_pipe: latency, all four modes, frame-boundary
// mode switching, ce stalls, mid-frame reset and an avg sweep of every sum.
module tb_rgb2luma_pipe;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [1:0]  cfg_mode;
    logic [7:0]  r, g, b;
    logic        vsync, hsync, de;
    logic        y_vsync, y_hsync, y_de;
    logic [7:0]  y;
    logic [23:0] rgb_out;
    logic [1:0]  mode_act;

    int checks = 0;
    int errors = 0;

    rgb2luma_pipe dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .cfg_mode (cfg_mode),
        .r        (r),
        .g        (g),
        .b        (b),
        .vsync    (vsync),
        .hsync    (hsync),
        .de       (de),
        .y_vsync  (y_vsync),
        .y_hsync  (y_hsync),
        .y_de     (y_de),
        .y        (y),
        .rgb_out  (rgb_out),
        .mode_act (mode_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int rv, input int gv, input int bv, input logic vs, input logic d);
        r     = 8'(rv);
        g     = 8'(gv);
        b     = 8'(bv);
        vsync = vs;
        de    = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        int s, rr, gg, bb;
        rst_n = 1'b0; ce = 1'b1; cfg_mode = 2'd0; hsync = 1'b0;
        px(0, 0, 0, 1'b0, 1'b0);
        step(); step();
        chk("rst_y", 32'(y), 0);
        chk("rst_de", 32'(y_de), 0);
        chk("rst_mode", 32'(mode_act), 0);
        chk("rst_rgb", 32'(rgb_out), 0);
        rst_n = 1'b1;

        // avg mode latency and rounding
        px(255, 255, 255, 1'b0, 1'b1); step();
        px(1, 1, 0, 1'b0, 1'b1);       step();
        chk("lat_y_early", 32'(y), 0);
        chk("lat_de_early", 32'(y_de), 0);
        px(2, 2, 2, 1'b0, 1'b1);       step();
        chk("avg_white", 32'(y), 255);
        chk("avg_white_de", 32'(y_de), 1);
        px(0, 0, 0, 1'b0, 1'b0);       step();
        chk("avg_110", 32'(y), 0);
        step();
        chk("avg_222", 32'(y), 2);

        // BT.601 and BT.709 selected at frame starts
        cfg_mode = 2'd1;
        px(255, 0, 0, 1'b1, 1'b1); step();
        px(0, 0, 0, 1'b0, 1'b0);   step(); step();
        chk("bt601_red", 32'(y), 77);
        chk("bt601_mode", 32'(mode_act), 1);
        chk("bt601_vs", 32'(y_vsync), 1);
        cfg_mode = 2'd2;
        px(0, 255, 0, 1'b1, 1'b1); step();
        px(0, 0, 0, 1'b0, 1'b0);   step(); step();
        chk("bt709_green", 32'(y), 182);
        chk("bt709_mode", 32'(mode_act), 2);

        // max mode and rgb passthrough
        cfg_mode = 2'd3; hsync = 1'b1;
        px(10, 200, 30, 1'b1, 1'b1); step();
        hsync = 1'b0;
        px(0, 0, 0, 1'b0, 1'b0);     step(); step();
        chk("max_y", 32'(y), 200);
        chk("max_rgb", 32'(rgb_out), 32'h0AC81E);
        chk("max_mode", 32'(mode_act), 3);
        chk("max_hs", 32'(y_hsync), 1);

        // mid-frame cfg change ignored until the next frame start
        cfg_mode = 2'd0;
        px(30, 60, 90, 1'b1, 1'b1); step();
        cfg_mode = 2'd1;
        px(255, 0, 0, 1'b0, 1'b1);  step();
        px(0, 0, 255, 1'b0, 1'b1);  step();
        chk("bnd_avg_first", 32'(y), 60);
        px(0, 255, 0, 1'b1, 1'b1);  step();
        chk("bnd_midframe_y", 32'(y), 85);
        chk("bnd_midframe_mode", 32'(mode_act), 0);
        px(0, 0, 255, 1'b1, 1'b1);  step();
        chk("bnd_inflight_y", 32'(y), 85);
        chk("bnd_inflight_mode", 32'(mode_act), 0);
        px(0, 0, 0, 1'b0, 1'b0);    step();
        chk("bnd_new_y", 32'(y), 149);
        chk("bnd_new_mode", 32'(mode_act), 1);
        step();
        chk("bnd_next_y", 32'(y), 29);

        // ce stall mid-line
        cfg_mode = 2'd0;
        px(3, 3, 3, 1'b1, 1'b1);    step();
        px(10, 10, 10, 1'b0, 1'b1); step();
        px(20, 20, 20, 1'b0, 1'b1); step();
        chk("stall_pre0", 32'(y), 3);
        px(30, 30, 30, 1'b0, 1'b1); step();
        chk("stall_pre1", 32'(y), 10);
        ce = 1'b0;
        px(99, 7, 250, 1'b1, 1'b0); cfg_mode = 2'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_hold_y", 32'(y), 10);
            chk("stall_hold_rgb", 32'(rgb_out), 32'h0A0A0A);
            chk("stall_hold_de", 32'(y_de), 1);
        end
        ce = 1'b1; cfg_mode = 2'd0;
        px(40, 40, 40, 1'b0, 1'b1); step();
        chk("stall_post0", 32'(y), 20);
        px(50, 50, 50, 1'b0, 1'b1); step();
        chk("stall_post1", 32'(y), 30);
        px(0, 0, 0, 1'b0, 1'b0);    step();
        chk("stall_post2", 32'(y), 40);
        step();
        chk("stall_post3", 32'(y), 50);
        chk("stall_post_mode", 32'(mode_act), 0);

        // mid-frame reset
        cfg_mode = 2'd3;
        px(5, 9, 7, 1'b1, 1'b1); step();
        px(5, 9, 7, 1'b0, 1'b1); step(); step();
        chk("prerst_y", 32'(y), 9);
        chk("prerst_mode", 32'(mode_act), 3);
        rst_n = 1'b0;
        #1;
        chk("midrst_y", 32'(y), 0);
        chk("midrst_de", 32'(y_de), 0);
        chk("midrst_mode", 32'(mode_act), 0);
        chk("midrst_rgb", 32'(rgb_out), 0);
        rst_n = 1'b1;
        px(9, 9, 9, 1'b0, 1'b1); step();
        chk("postrst_de0", 32'(y_de), 0);
        step();
        chk("postrst_de1", 32'(y_de), 0);
        chk("postrst_mode", 32'(mode_act), 0);
        step();
        chk("postrst_de2", 32'(y_de), 1);
        chk("postrst_y", 32'(y), 9);

        // avg over every reachable channel sum
        for (int i = 0; i < 768; i++) begin
            if (i < 766) begin
                s  = i;
                rr = (s > 255) ? 255 : s;
                s  = s - rr;
                gg = (s > 255) ? 255 : s;
                bb = s - gg;
                px(rr, gg, bb, 1'b0, 1'b1);
            end else begin
                px(0, 0, 0, 1'b0, 1'b0);
            end
            step();
            if (i >= 2)
                chk("avg_sweep", 32'(y), 32'((i - 2) / 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
